jc_decoder: RTL

Receive-side companion to the team's Johnson counters. It samples an N-stage Johnson code, decodes it to a binary phase index and a one-hot phase vector, and checks both code legality and step-to-step sequencing. It sits downstream of any Johnson-counter-driven sequencer that needs phase decode plus integrity monitoring. The block locks onto the sequence after a run of correct steps.

---
 rtl/jcd_pkg.sv | 21 ++
 rtl/jc_code_check.sv | 45 ++++
 rtl/jc_decoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/jcd_pkg.sv
// Shared types and helpers for the Johnson-code decoder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jcd_pkg;

    // Sequence-integrity FSM states.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } jcd_state_t;

    // Lock-run counter width. It covers a lock length of up to 15 steps.
    localparam int RUN_W = 4;

    // Width of a phase index for an n-stage Johnson code (2n phases).
    function automatic int jcd_iw(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/jc_code_check.sv
// Combinational Johnson-code interpreter: legality and phase index of one code.
// Latency: zero (purely combinational).
// Backpressure: none; the result is valid whenever the code is valid.
//
// Ports:
//   code  : N-bit Johnson code under test
//   legal : 1 when code has at most one adjacent-bit value change
//   idx   : phase index. 0 for all-zero; popcount when MSB=1; 2N-popcount otherwise
module jc_code_check
    import jcd_pkg::*;
#(
    parameter int N = 3,
    localparam int IW = jcd_iw(N)
) (
    input  logic [N-1:0]  code,
    output logic          legal,
    output logic [IW-1:0] idx
);

    int ones;
    int edges;

    always_comb begin
        ones  = 0;
        edges = 0;
        for (int i = 0; i < N; i++) begin
            if (code[i]) ones = ones + 1;
        end
        for (int i = 0; i < N - 1; i++) begin
            if (code[i] != code[i+1]) edges = edges + 1;
        end
        legal = (edges <= 1);

        // A filling run of ones from the MSB gives phases 1..N. A draining run
        // (the MSB is already clear) gives phases N+1..2N-1.
        if (ones == 0) begin
            idx = '0;
        end else if (code[N-1]) begin
            idx = IW'(ones);
        end else begin
            idx = IW'(2 * N - ones);
        end
    end

endmodule

// File: rtl/jc_decoder.sv
// Johnson-code receiver: phase decode, legality check, sequencing check and lock FSM.
// Latency: all outputs are registered, one cycle after an i_en sample.
// Backpressure: none; each i_en=1 cycle is one sample, and i_en=0 holds the state.
//
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_en, i_Q          : sample strobe and N-bit Johnson code
//   o_idx, o_onehot    : decoded phase (binary / one-hot)
//   o_valid            : last sample was a legal code
//   o_illegal          : pulse, the sample was not a Johnson code
//   o_seq_err          : pulse, legal code that is not the expected successor
//   o_locked           : FSM is in LOCKED
//   o_err_cnt          : saturating count of illegal and sequence errors
// Build option: define JCD_HOLD_OK_EN to accept a repeated index as a hold.
module jc_decoder
    import jcd_pkg::*;
#(
    parameter int N        = 3,
    parameter int LOCK_LEN = 4,
    parameter int CNT_W    = 8,
    localparam int IW      = jcd_iw(N)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [N-1:0]     i_Q,
    output logic [IW-1:0]    o_idx,
    output logic [2*N-1:0]   o_onehot,
    output logic             o_valid,
    output logic             o_illegal,
    output logic             o_seq_err,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam logic [IW-1:0]  LAST_IDX = IW'(2 * N - 1);
    localparam logic [2*N-1:0] ONE_HOT0 = {{(2*N-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_LEN - 1);

    jcd_state_t       state;
    logic [RUN_W-1:0] run;
    logic [IW-1:0]    prev_idx;

    logic             code_legal;
    logic [IW-1:0]    code_idx;
    logic [IW-1:0]    succ_idx;
    logic             is_succ;
    logic             is_hold;

    jc_code_check #(.N(N)) u_check (
        .code  (i_Q),
        .legal (code_legal),
        .idx   (code_idx)
    );

    always_comb begin
        succ_idx = (prev_idx == LAST_IDX) ? '0 : prev_idx + 1'b1;
        is_succ  = (code_idx == succ_idx);
`ifdef JCD_HOLD_OK_EN
        is_hold  = (code_idx == prev_idx);
`else
        is_hold  = 1'b0;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= HUNT;
            run       <= '0;
            prev_idx  <= '0;
            o_idx     <= '0;
            o_onehot  <= '0;
            o_valid   <= 1'b0;
            o_illegal <= 1'b0;
            o_seq_err <= 1'b0;
            o_locked  <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            // The error pulses last one cycle. They are re-raised below only when
            // a sample fails a check.
            o_illegal <= 1'b0;
            o_seq_err <= 1'b0;

            if (i_en) begin
                if (!code_legal) begin
                    // o_idx and prev_idx keep the last good phase.
                    o_illegal <= 1'b1;
                    o_valid   <= 1'b0;
                    o_onehot  <= '0;
                    state     <= HUNT;
                    o_locked  <= 1'b0;
                    run       <= '0;
                    if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
                end else begin
                    o_idx    <= code_idx;
                    o_onehot <= ONE_HOT0 << code_idx;
                    o_valid  <= 1'b1;
                    prev_idx <= code_idx;

                    if (state == HUNT) begin
                        state    <= CHECK;
                        o_locked <= 1'b0;
                        run      <= '0;
                    end else if (is_hold) begin
                        // A paused source: not a step and not an error.
                        o_locked <= (state == LOCKED);
                    end else if (is_succ) begin
                        if (state == CHECK) begin
                            if (run == RUN_LAST) begin
                                state    <= LOCKED;
                                o_locked <= 1'b1;
                            end else begin
                                o_locked <= 1'b0;
                            end
                            run <= run + 1'b1;
                        end else begin
                            o_locked <= 1'b1;
                        end
                    end else begin
                        // The new phase becomes the reference for the next checks.
                        o_seq_err <= 1'b1;
                        state     <= CHECK;
                        o_locked  <= 1'b0;
                        run       <= '0;
                        if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule
